parking_gate_arbiter: RTL and testbench
=======================================

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  CAPACITY     8    maximum number of parked cars
  OPEN_CYCLES  16   clock cycles the barrier stays open per grant, minimum 1
  CNT_W        4    occupancy counter width; must satisfy 2**CNT_W > CAPACITY
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk        in   1      single clock; all logic on its rising edge
  reset      in   1      synchronous, active-high reset
  req_in     in   1      entrance requester; level, held until granted
  req_out    in   1      exit requester; level, held until granted
  grant_in   out  1      one-cycle pulse when entry wins the gate
  grant_out  out  1      one-cycle pulse when exit wins the gate
  gate_open  out  1      barrier open command
  busy       out  1      high in any state other than IDLE
  done       out  1      one-cycle pulse marking end of a passage
  deny_in    out  1      pulse: entry request refused because the lot is full
  deny_out   out  1      pulse: exit request refused because the lot is empty
  occupancy  out  CNT_W  current car count
  full       out  1      occupancy == CAPACITY
  empty      out  1      occupancy == 0
REQ-003 Clock and reset SHALL be exactly as stated: one clock, and a synchronous, active-high reset.

Function
REQ-004 The block SHALL be an FSM with states IDLE, OPEN, and CLOSE; all outputs SHALL be registered.
REQ-005 In IDLE, an entry request is eligible when req_in && !full, and an exit request is eligible when req_out && !empty.
REQ-006 In IDLE with exactly one eligible request sampled at edge N, the matching grant SHALL pulse in cycle N+1 and the FSM SHALL enter OPEN.
REQ-007 In OPEN, gate_open SHALL be high for exactly OPEN_CYCLES cycles, starting in the grant cycle, counted by a down-counter.
REQ-008 CLOSE SHALL last one cycle with gate_open=0 and done=1.
  Occupancy SHALL be +1 for an entry or -1 for an exit, visible in the done cycle.
  The last-served direction SHALL be recorded; the FSM then returns to IDLE.
REQ-009 The earliest next grant SHALL come one cycle after done.
  Back-to-back passage period is OPEN_CYCLES+2 cycles.
REQ-010 When both requests are eligible, the direction not served last SHALL win (round-robin); after reset, entry wins first.
REQ-011 Requests SHALL be ignored outside IDLE, with no queueing; a requester holding its req SHALL be evaluated on return to IDLE.
REQ-012 deny_in SHALL pulse in each IDLE cycle where req_in && full; no grant_in SHALL be issued, and an eligible exit still proceeds.
REQ-013 deny_out SHALL pulse in each IDLE cycle where req_out && empty; no grant_out SHALL be issued.
REQ-014 Occupancy SHALL never exceed CAPACITY or go below 0; full and empty SHALL be decoded from registered occupancy.
REQ-015 Deasserting req after its grant SHALL NOT abort the passage.

Reset
REQ-016 On reset, the FSM SHALL go to IDLE with timer=0 and occupancy=0.
  Outputs SHALL be empty=1 and full=0.
  All pulse outputs, gate_open, and busy SHALL be 0.
  The last-served direction SHALL be set to exit.
REQ-017 Reset mid-OPEN SHALL close the gate the next cycle with no done pulse and no occupancy change.

Configuration
REQ-018 Macro PARKING_EXIT_PRIORITY_EN SHALL select the arbitration policy.
  When defined, an eligible exit SHALL always win simultaneous requests (REQ-010 replaced).
  When undefined, round-robin per REQ-010 SHALL apply.
  All other behaviour SHALL be identical in both builds.

Verification (CAPACITY=2, OPEN_CYCLES=4, macro undefined unless noted)
REQ-019 Reset, then req_in at cycle 0 -> grant_in at cycle 1; gate_open in cycles 1-4; done at cycle 5 with occupancy=1.
REQ-020 Two entries, then req_in held -> after occupancy=2, full=1, deny_in pulses every IDLE cycle, and no grant_in.
REQ-021 occupancy=1, req_in and req_out together -> grant_in first (last=exit), then grant_out 6 cycles later, and occupancy returns to 1.
REQ-022 Same stimulus with PARKING_EXIT_PRIORITY_EN defined -> grant_out first, occupancy 0, then grant_in.
REQ-023 req_out on an empty lot -> deny_out pulse, no grant, occupancy stays 0.
REQ-024 reset asserted during cycle 2 of OPEN -> gate_open=0 the next cycle, no done pulse, occupancy=0.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Single-lane parking barrier arbiter: grants entry/exit passages, times the open barrier, tracks occupancy.
// Define PARKING_EXIT_PRIORITY_EN to make exit always win simultaneous requests; otherwise round-robin.
module parking_gate_arbiter #(
  parameter int CAPACITY    = 8,
  parameter int OPEN_CYCLES = 16,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
  output logic             grant_in,
  output logic             grant_out,
  output logic             gate_open,
  output logic             busy,
  output logic             done,
  output logic             deny_in,
  output logic             deny_out,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  localparam int TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [CNT_W-1:0]   occ_n;
  logic               last_exit, last_exit_n;
  logic               dir_exit, dir_exit_n;
  logic               grant_in_n, grant_out_n, done_n, deny_in_n, deny_out_n;
  logic               elig_in, elig_out, pick_exit;

  assign elig_in  = req_in && !full;
  assign elig_out = req_out && !empty;

`ifdef PARKING_EXIT_PRIORITY_EN
  assign pick_exit = elig_out;
`else
  // On a tie, serve whichever direction did not go last.
  assign pick_exit = elig_out && (!elig_in || !last_exit);
`endif

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    occ_n       = occupancy;
    last_exit_n = last_exit;
    dir_exit_n  = dir_exit;
    grant_in_n  = 1'b0;
    grant_out_n = 1'b0;
    done_n      = 1'b0;
    deny_in_n   = 1'b0;
    deny_out_n  = 1'b0;
    case (state)
      IDLE: begin
        deny_in_n  = req_in && full;
        deny_out_n = req_out && empty;
        if (elig_in || elig_out) begin
          state_n     = OPEN;
          timer_n     = TMR_LOAD;
          dir_exit_n  = pick_exit;
          grant_out_n = pick_exit;
          grant_in_n  = !pick_exit;
        end
      end
      OPEN: begin
        if (timer == '0) begin
          state_n = CLOSE;
          done_n  = 1'b1;
          occ_n   = dir_exit ? occupancy - CNT_W'(1) : occupancy + CNT_W'(1);
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      CLOSE: begin
        state_n     = IDLE;
        last_exit_n = dir_exit;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      occupancy <= '0;
      last_exit <= 1'b1;
      dir_exit  <= 1'b0;
      grant_in  <= 1'b0;
      grant_out <= 1'b0;
      gate_open <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      deny_in   <= 1'b0;
      deny_out  <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      occupancy <= occ_n;
      last_exit <= last_exit_n;
      dir_exit  <= dir_exit_n;
      grant_in  <= grant_in_n;
      grant_out <= grant_out_n;
      gate_open <= (state_n == OPEN);
      busy      <= (state_n != IDLE);
      done      <= done_n;
      deny_in   <= deny_in_n;
      deny_out  <= deny_out_n;
      full      <= (occ_n == CAP);
      empty     <= (occ_n == '0);
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: fixed vector table, directed corner sequences, randomized run vs passage-level model.
module tb_parking_gate_arbiter;
  localparam int CAP = 2;
  localparam int OC  = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, req_in = 1'b0, req_out = 1'b0;
  logic grant_in, grant_out, gate_open, busy, done, deny_in, deny_out, full, empty;
  logic [CW-1:0] occupancy;

  parking_gate_arbiter #(.CAPACITY(CAP), .OPEN_CYCLES(OC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .req_out(req_out),
    .grant_in(grant_in), .grant_out(grant_out), .gate_open(gate_open), .busy(busy),
    .done(done), .deny_in(deny_in), .deny_out(deny_out), .occupancy(occupancy),
    .full(full), .empty(empty));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Passage-level model: pos is cycles since grant (-1 when idle).
  int pos = -1;
  int occ = 0;
  bit last_exit_m = 1'b1, dir_m = 1'b0;
  bit m_gi, m_go, m_di, m_do;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit ri, input bit ro);
    bit ok_in, ok_out, take_exit;
    m_gi = 0; m_go = 0; m_di = 0; m_do = 0;
    if (r) begin
      pos = -1; occ = 0; last_exit_m = 1'b1;
    end else if (pos < 0) begin
      ok_in  = ri && (occ < CAP);
      ok_out = ro && (occ > 0);
      m_di   = ri && (occ == CAP);
      m_do   = ro && (occ == 0);
      if (ok_in || ok_out) begin
`ifdef PARKING_EXIT_PRIORITY_EN
        take_exit = ok_out;
`else
        take_exit = ok_out && (!ok_in || !last_exit_m);
`endif
        dir_m = take_exit;
        pos = 0;
        m_gi = !take_exit;
        m_go = take_exit;
      end
    end else begin
      pos++;
      if (pos == OC) occ += dir_m ? -1 : 1;
      else if (pos > OC) begin
        pos = -1;
        last_exit_m = dir_m;
      end
    end
  endtask

  function automatic logic [12:0] model_vec();
    return {m_gi, m_go, (pos >= 0 && pos < OC), (pos >= 0), (pos == OC), m_di, m_do,
            (occ == CAP), (occ == 0), 4'(occ)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {grant_in, grant_out, gate_open, busy, done, deny_in, deny_out, full, empty, occupancy};
  endfunction

  task automatic step(input bit r, input bit ri, input bit ro);
    reset = r; req_in = ri; req_out = ro;
    @(posedge clk);
    model_edge(r, ri, ro);
    #1;
    chk("model", int'(dut_vec()), int'(model_vec()));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      step(0, 0, 0);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic passage(input bit ex);
    int n = 0;
    do begin
      step(0, !ex, ex);
      n++;
    end while (!(ex ? grant_out : grant_in) && n < 20);
    chk("grant_timeout", int'(ex ? grant_out : grant_in), 1);
    wait_idle();
  endtask

  typedef struct {
    bit rst, ri, ro;
    bit gi, go, gate, bsy, dn, di, dno;
    int occ;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int cnt_deny, cnt_grant, k;
    bit first_exit, second_exit, got;
    bit hold_in, hold_out;

    tbl[0]  = '{1,0,0, 0,0,0,0,0,0,0, 0};
    tbl[1]  = '{0,1,0, 1,0,1,1,0,0,0, 0};
    tbl[2]  = '{0,0,0, 0,0,1,1,0,0,0, 0};
    tbl[3]  = '{0,0,0, 0,0,1,1,0,0,0, 0};
    tbl[4]  = '{0,0,0, 0,0,1,1,0,0,0, 0};
    tbl[5]  = '{0,0,0, 0,0,0,1,1,0,0, 1};
    tbl[6]  = '{0,0,0, 0,0,0,0,0,0,0, 1};
    tbl[7]  = '{0,0,1, 0,1,1,1,0,0,0, 1};
    tbl[8]  = '{0,0,0, 0,0,1,1,0,0,0, 1};
    tbl[9]  = '{0,0,0, 0,0,1,1,0,0,0, 1};
    tbl[10] = '{0,0,0, 0,0,1,1,0,0,0, 1};
    tbl[11] = '{0,0,0, 0,0,0,1,1,0,0, 0};
    tbl[12] = '{0,0,1, 0,0,0,0,0,0,0, 0};  // request during CLOSE is ignored
    tbl[13] = '{0,0,1, 0,0,0,0,0,0,1, 0};
    tbl[14] = '{0,0,0, 0,0,0,0,0,0,0, 0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].ri, tbl[i].ro);
      chk($sformatf("table[%0d]", i), int'(dut_vec()),
          int'({tbl[i].gi, tbl[i].go, tbl[i].gate, tbl[i].bsy, tbl[i].dn, tbl[i].di, tbl[i].dno,
                (tbl[i].occ == CAP), (tbl[i].occ == 0), 4'(tbl[i].occ)}));
    end

    // Full lot: held entry request is denied every idle cycle, never granted.
    step(1, 0, 0);
    passage(0);
    passage(0);
    chk("full_flag", int'(full), 1);
    cnt_deny = 0; cnt_grant = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0);
      cnt_deny += int'(deny_in);
      cnt_grant += int'(grant_in);
    end
    chk("full_deny_count", cnt_deny, 10);
    chk("full_grant_count", cnt_grant, 0);

    // Simultaneous requests at occupancy 1 with exit served last.
    step(1, 0, 0);
    passage(0);
    passage(0);
    passage(1);
    chk("tie_occ_start", int'(occupancy), 1);
    k = 0; got = 0;
    while (!got && k < 20) begin
      step(0, 1, 1);
      k++;
      got = grant_in || grant_out;
    end
    first_exit = grant_out;
    chk("tie_first_seen", int'(got), 1);
`ifdef PARKING_EXIT_PRIORITY_EN
    chk("tie_first_exit", int'(first_exit), 1);
`else
    chk("tie_first_exit", int'(first_exit), 0);
`endif
    k = 0; got = 0;
    while (!got && k < 20) begin
      step(0, 1, 1);
      k++;
      got = grant_in || grant_out;
    end
    second_exit = grant_out;
    chk("tie_second_gap", k, OC + 2);
    chk("tie_second_dir", int'(second_exit), int'(!first_exit));
    wait_idle();
    chk("tie_occ_end", int'(occupancy), 1);

    // Exit request on an empty lot.
    step(1, 0, 0);
    cnt_deny = 0; cnt_grant = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      cnt_deny += int'(deny_out);
      cnt_grant += int'(grant_out);
    end
    chk("empty_deny_count", cnt_deny, 3);
    chk("empty_grant_count", cnt_grant, 0);
    chk("empty_occ", int'(occupancy), 0);

    // Reset in the second OPEN cycle.
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("rst_open_gate", int'(gate_open), 0);
    chk("rst_open_done", int'(done), 0);
    step(0, 0, 0);
    chk("rst_open_done_after", int'(done), 0);
    chk("rst_open_occ", int'(occupancy), 0);

    // Randomized held-request traffic with occasional reset.
    hold_in = 0; hold_out = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) hold_in = ~hold_in;
      if ($urandom_range(0, 3) == 0) hold_out = ~hold_out;
      step(($urandom_range(0, 99) == 0), hold_in, hold_out);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
